// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu : multiply / divide unit with HI/LO result registers.
//
// A multicycle multiply/divide engine in the style of a classic MIPS HI/LO
// unit. An operation is accepted only while idle; the operands are latched at
// acceptance, busy is held for exactly MUL_CYC or DIV_CYC cycles, and HI/LO
// are written on the final edge of the operation, so the new values appear in
// the same cycle in which busy first reads 0. MTHI/MTLO write HI/LO directly
// in a single edge without becoming busy.
//
// Handshake: start is a one-cycle request, honoured only on an edge where the
// unit is idle (busy=0). Requests seen while busy are dropped, not queued, so
// the issuer must wait for busy=0 before issuing the next multiply/divide.
// A request made on the very cycle busy first reads 0 is accepted.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous active-high reset, beats start
//   start        in   request strobe for op
//   op[2:0]      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A[31:0]      in   operand A (dividend, or MTHI/MTLO source)
//   B[31:0]      in   operand B (divisor)
//   busy         out  registered, high while a multiply/divide is in flight
//   HI[31:0]     out  registered HI contents
//   LO[31:0]     out  registered LO contents
//   o_dbg_run    out  FSM state (1 = RUN)
//   o_dbg_cnt    out  remaining-cycle down-counter
// -----------------------------------------------------------------------------
module mdu #(
   parameter int MUL_CYC = 5,
   parameter int DIV_CYC = 10,
   localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC,
   localparam int CNT_W   = $clog2(MAX_CYC + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [31:0]      A,
   input  logic [31:0]      B,
   output logic             busy,
   output logic [31:0]      HI,
   output logic [31:0]      LO,
   output logic             o_dbg_run,
   output logic [CNT_W-1:0] o_dbg_cnt
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [1:0]       r_op;     // only ops 0-3 are ever latched
   logic             r_busy;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   // ---------------------------------------------------------------------------
   // Result datapath, driven only by the latched operands so that activity on
   // A/B/op during RUN cannot reach the result.
   // ---------------------------------------------------------------------------
   logic        w_is_div;
   logic        w_signed;
   logic [63:0] w_mul_a;
   logic [63:0] w_mul_b;
   logic [63:0] w_prod;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_div_b;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_div_zero;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   assign w_is_div = r_op[1];
   assign w_signed = ~r_op[0];

   // Extending to 64 bits first makes one unsigned multiplier serve both the
   // signed and unsigned forms; the low 64 bits are exact in both cases.
   assign w_mul_a = w_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
   assign w_mul_b = w_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
   assign w_prod  = w_mul_a * w_mul_b;

   // Signed division is done on magnitudes. The magnitude of 0x80000000 is
   // 2^31, which still fits unsigned, so 0x80000000 / -1 naturally yields
   // quotient 0x80000000 and remainder 0 without a special case.
   assign w_a_neg    = w_signed & r_a[31];
   assign w_b_neg    = w_signed & r_b[31];
   assign w_abs_a    = w_a_neg ? (~r_a + 32'd1) : r_a;
   assign w_abs_b    = w_b_neg ? (~r_b + 32'd1) : r_b;
   assign w_div_zero = (r_b == 32'd0);
   // Substitute a harmless divisor for zero; the result is discarded anyway.
   assign w_div_b    = w_div_zero ? 32'd1 : w_abs_b;
   assign w_q_mag    = w_abs_a / w_div_b;
   assign w_r_mag    = w_abs_a % w_div_b;
   // Quotient truncates toward zero; remainder follows the dividend's sign.
   assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_rem      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

   assign w_res_hi = w_is_div ? w_rem  : w_prod[63:32];
   assign w_res_lo = w_is_div ? w_quot : w_prod[31:0];

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 2'd0;
         r_busy  <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  unique case (op)
                     3'd0, 3'd1: begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op[1:0];
                        r_cnt   <= CNT_W'(MUL_CYC);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                     end
                     3'd2, 3'd3: begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op[1:0];
                        r_cnt   <= CNT_W'(DIV_CYC);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                     end
                     3'd4:    r_hi <= A;
                     3'd5:    r_lo <= A;
                     default: ; // reserved ops do nothing
                  endcase
               end
            end
            S_RUN: begin
               // start is deliberately not looked at here.
               if (r_cnt == CNT_W'(1)) begin
                  // A zero divisor burns the full latency but leaves HI/LO.
                  if (!(w_is_div && w_div_zero)) begin
                     r_hi <= w_res_hi;
                     r_lo <= w_res_lo;
                  end
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign HI        = r_hi;
   assign LO        = r_lo;
   assign o_dbg_run = (r_state == S_RUN);
   assign o_dbg_cnt = r_cnt;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu : self-checking bench for mdu.
//
// A transaction-level model predicts busy/HI/LO for every edge: an accepted
// multiply/divide computes its result immediately with plain arithmetic and
// publishes it after a fixed number of edges. Directed scenarios add literal
// expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mdu;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        dbg_run;
   logic [3:0]  dbg_cnt;

   always #5 clk = ~clk;

   mdu #(.MUL_CYC(MUL_LAT), .DIV_CYC(DIV_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .HI        (HI),
      .LO        (LO),
      .o_dbg_run (dbg_run),
      .o_dbg_cnt (dbg_cnt)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid = 1'b0;
   bit          m_busy  = 1'b0;
   int          m_rem   = 0;
   logic [31:0] m_hi    = 32'd0;
   logic [31:0] m_lo    = 32'd0;
   bit          p_write = 1'b0;
   logic [31:0] p_hi    = 32'd0;
   logic [31:0] p_lo    = 32'd0;

   // Advance the model by one rising edge given the inputs present at it.
   task automatic model_edge(input logic rst, input logic st, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa;
      int          sb;
      sa = a;
      sb = b;
      if (rst) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_rem   = 0;
         m_hi    = 32'd0;
         m_lo    = 32'd0;
      end else if (m_busy) begin
         m_rem--;
         if (m_rem == 0) begin
            m_busy = 1'b0;
            if (p_write) begin
               m_hi = p_hi;
               m_lo = p_lo;
            end
         end
      end else if (st) begin
         case (o)
            3'd0: begin
               sp = longint'(sa) * longint'(sb);
               p_hi = sp[63:32]; p_lo = sp[31:0]; p_write = 1'b1;
            end
            3'd1: begin
               up = {32'd0, a} * {32'd0, b};
               p_hi = up[63:32]; p_lo = up[31:0]; p_write = 1'b1;
            end
            3'd2: begin
               if (b == 32'd0) p_write = 1'b0;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  p_lo = 32'h8000_0000; p_hi = 32'd0; p_write = 1'b1;
               end else begin
                  p_lo = sa / sb; p_hi = sa % sb; p_write = 1'b1;
               end
            end
            3'd3: begin
               if (b == 32'd0) p_write = 1'b0;
               else begin
                  p_lo = a / b; p_hi = a % b; p_write = 1'b1;
               end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
         endcase
         if (o < 3'd4) begin
            m_busy = 1'b1;
            m_rem  = (o < 3'd2) ? MUL_LAT : DIV_LAT;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Drive one cycle, predict, then compare outputs 1ns after the edge.
   task automatic cycle(input logic rst, input logic st, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
      reset = rst; start = st; op = o; A = a; B = b;
      model_edge(rst, st, o, a, b);
      @(posedge clk);
      #1;
      if (m_valid) begin
         check32("busy", {31'd0, busy}, {31'd0, m_busy});
         check32("HI", HI, m_hi);
         check32("LO", LO, m_lo);
      end
   endtask

   // Idle cycles: start low, other inputs scrambled to prove they are ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
   endtask

   // Issue an op and count the cycles busy reads high (bounded).
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat);
      int n;
      cycle(1'b0, 1'b1, o, a, b);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         idle(1);
      end
      check32({name, "_latency"}, n, exp_lat);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
      @(posedge clk); #1;
      cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_HI", HI, 32'd0);
      check32("reset_LO", LO, 32'd0);

      // Signed multiply of -2 * 3.
      run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 5);
      check32("mult_HI", HI, 32'hFFFF_FFFF);
      check32("mult_LO", LO, 32'hFFFF_FFFA);

      // Unsigned max * max, issued back-to-back with no dead cycle.
      run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
      check32("multu_HI", HI, 32'hFFFF_FFFE);
      check32("multu_LO", LO, 32'h0000_0001);

      // -7 / 2, signed then unsigned.
      run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
      check32("div_LO", LO, 32'hFFFF_FFFD);
      check32("div_HI", HI, 32'hFFFF_FFFF);
      run_op("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 10);
      check32("divu_LO", LO, 32'h7FFF_FFFC);
      check32("divu_HI", HI, 32'h0000_0001);

      // Overflowing signed divide.
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      check32("div_ovf_LO", LO, 32'h8000_0000);
      check32("div_ovf_HI", HI, 32'h0000_0000);

      // MTHI/MTLO preload, then divide by zero leaves them alone.
      cycle(1'b0, 1'b1, 3'd4, 32'h1111_1111, 32'd0);
      check32("mthi_busy", {31'd0, busy}, 32'd0);
      cycle(1'b0, 1'b1, 3'd5, 32'h2222_2222, 32'd0);
      check32("mtlo_busy", {31'd0, busy}, 32'd0);
      run_op("divu0", 3'd3, 32'h1234_5678, 32'd0, 10);
      check32("divu0_HI", HI, 32'h1111_1111);
      check32("divu0_LO", LO, 32'h2222_2222);

      // Requests during RUN are ignored.
      cycle(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
      idle(1);
      cycle(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
      cycle(1'b0, 1'b1, 3'd0, 32'd100, 32'd200);
      cycle(1'b0, 1'b1, 3'd7, 32'd9, 32'd9);
      idle(2);
      check32("ignore_busy", {31'd0, busy}, 32'd0);
      check32("ignore_HI", HI, 32'd0);
      check32("ignore_LO", LO, 32'h0000_000C);

      // Reserved op while idle is a no-op.
      cycle(1'b0, 1'b1, 3'd6, 32'hAAAA_AAAA, 32'd1);
      check32("nop_busy", {31'd0, busy}, 32'd0);
      check32("nop_LO", LO, 32'h0000_000C);

      // Reset on cycle 4 of a divide aborts it for good.
      cycle(1'b0, 1'b1, 3'd2, 32'd100, 32'd7);
      idle(2);
      cycle(1'b1, 1'b1, 3'd0, 32'd5, 32'd5);
      check32("abort_busy", {31'd0, busy}, 32'd0);
      check32("abort_HI", HI, 32'd0);
      check32("abort_LO", LO, 32'd0);
      idle(12);
      check32("abort_late_HI", HI, 32'd0);
      check32("abort_late_LO", LO, 32'd0);
      run_op("post_reset", 3'd1, 32'd2, 32'd5, 5);
      check32("post_reset_LO", LO, 32'h0000_000A);
      check32("post_reset_HI", HI, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
               3'($urandom_range(0, 7)), rand_operand(), rand_operand());
      end
      idle(12);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning): MUL_CYC, 5, multiply latency in cycles; DIV_CYC, 10, divide latency in cycles.
REQ-002 The block SHALL provide port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL provide port start, input, 1, request to start or perform the operation on op.
REQ-005 The block SHALL provide port op, input, 3, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op).
REQ-006 The block SHALL provide ports A and B, input, 32 each: operand A (dividend, or MTHI/MTLO source) and operand B (divisor).
REQ-007 The block SHALL provide port busy, output, 1, registered; high while a multiply/divide is in flight.
REQ-008 The block SHALL provide ports HI and LO, output, 32 each, registered; current HI/LO register contents, read by mfhi/mflo.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (busy=0) and RUN (busy=1), with a down-counter cnt.
REQ-010 In IDLE, start=1 with op in 0-3 SHALL latch A, B and op, load cnt with MUL_CYC (ops 0-1) or DIV_CYC (ops 2-3), and enter RUN; busy is 1 from the next cycle.
REQ-011 In RUN, each edge SHALL decrement cnt; on the edge where cnt==1, the block SHALL write HI/LO with the result, set busy=0 and return to IDLE, so busy stays high for exactly MUL_CYC or DIV_CYC cycles.
REQ-012 HI/LO SHALL keep their old values throughout RUN; the new values SHALL be visible in the same cycle in which busy first reads 0.
REQ-013 MULT SHALL compute the signed 64-bit product of the latched A and B, and MULTU the unsigned one; HI = bits 63:32 and LO = bits 31:0.
REQ-014 DIV SHALL compute a signed quotient in LO, truncated toward zero, and the remainder in HI, with the remainder taking the sign of the dividend; DIVU SHALL do the same with unsigned operands.
REQ-015 For DIV, 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-016 For a divisor of 0 (DIV or DIVU), the block SHALL still take DIV_CYC cycles, then leave HI and LO unchanged.
REQ-017 In IDLE, start=1 with op=4 (MTHI) or op=5 (MTLO) SHALL write A to HI or LO on that edge; busy SHALL stay 0.
REQ-018 start=1 during RUN, for any op, SHALL be ignored: no state, operand or HI/LO change.
REQ-019 start=1 with op 6-7 SHALL be a no-op in either state.
REQ-020 Results SHALL use only the operands latched at start; changes on A, B or op during RUN SHALL have no effect.
REQ-021 Back-to-back use SHALL be allowed: start on the cycle busy first reads 0 SHALL be accepted, giving no dead cycle.

Reset
REQ-022 reset=1 SHALL, on the next rising edge, set busy=0, HI=0, LO=0, cnt=0 and FSM=IDLE, and SHALL take priority over start.
REQ-023 reset asserted during RUN SHALL abort the operation; no result SHALL ever be written for it.

Verification
REQ-024 The bench SHALL apply MULT with A=0xFFFFFFFE (-2) and B=0x00000003, and SHALL check: busy high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-025 The bench SHALL apply MULTU with A=0xFFFFFFFF and B=0xFFFFFFFF, and SHALL check: HI=0xFFFFFFFE and LO=0x00000001 after 5 cycles.
REQ-026 The bench SHALL apply DIV with A=0xFFFFFFF9 (-7) and B=2, and SHALL check: busy high for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1); the same inputs with DIVU SHALL give LO=0x7FFFFFFC and HI=0x00000001.
REQ-027 The bench SHALL preload HI=0x11111111 and LO=0x22222222 via MTHI/MTLO (busy stays 0), apply DIVU with B=0, and SHALL check: after 10 cycles HI and LO are unchanged.
REQ-028 The bench SHALL start MULT (A=3, B=4), pulse MTLO with A=0xDEADBEEF and a second MULT during RUN, and SHALL check: the pulses are ignored and the result is HI=0 and LO=0x0000000C.
REQ-029 The bench SHALL start DIV (A=100, B=7), assert reset at cycle 4 of RUN, and SHALL check: next edge busy=0, HI=0 and LO=0, with no later update; a new MULTU (A=2, B=5) then SHALL give LO=0x0000000A.
